// File: rtl/low_freq_queue.sv
// ---------------------------------------------------------------------------
// low_freq_queue: stereo sample history buffer that streams all DEPTH stored
// samples, oldest first, to the downstream FIR each time the queue is full.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module low_freq_queue #(
  parameter int DEPTH = 1021,
  parameter int AW    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
  output logic               sequencing,
  output logic               full,
  output logic               ovrflw
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic signed [15:0] mem_l [DEPTH];
  logic signed [15:0] mem_r [DEPTH];

  state_t             state_q, state_d;
  logic [AW-1:0]      new_ptr_q, new_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               seq_q, seq_d;
  logic               ovf_q, ovf_d;
  logic signed [15:0] lft_q, lft_d;
  logic signed [15:0] rght_q, rght_d;
  logic               wr_en;

  function automatic logic [AW-1:0] inc_wrap(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    new_ptr_d = new_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_cnt_d  = rd_cnt_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    lft_d     = lft_q;
    rght_d    = rght_q;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wrt_smpl) begin
          wr_en     = 1'b1;
          new_ptr_d = inc_wrap(new_ptr_q);
          if (cnt_q != FULL_CNT) cnt_d = cnt_q + 1'b1;
          // Post-write pointer is the oldest entry once the queue is full
          if (cnt_d == FULL_CNT) begin
            state_d  = READ;
            rd_ptr_d = new_ptr_d;
            rd_cnt_d = '0;
          end
        end
      end
      READ: begin
        lft_d    = mem_l[rd_ptr_q];
        rght_d   = mem_r[rd_ptr_q];
        rd_ptr_d = inc_wrap(rd_ptr_q);
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_IDX) state_d = IDLE;
        if (wrt_smpl) ovf_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Read data lands one cycle after the address, so delay the READ flag too
    seq_d = (state_q == READ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      new_ptr_q <= '0;
      rd_ptr_q  <= '0;
      rd_cnt_q  <= '0;
      cnt_q     <= '0;
      seq_q     <= 1'b0;
      ovf_q     <= 1'b0;
      lft_q     <= '0;
      rght_q    <= '0;
    end else begin
      state_q   <= state_d;
      new_ptr_q <= new_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_cnt_q  <= rd_cnt_d;
      cnt_q     <= cnt_d;
      seq_q     <= seq_d;
      ovf_q     <= ovf_d;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
    end
  end

  // Sample storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_l[new_ptr_q] <= lft_smpl;
      mem_r[new_ptr_q] <= rght_smpl;
    end
  end

  assign lft_out    = lft_q;
  assign rght_out   = rght_q;
  assign sequencing = seq_q;
  assign full       = (cnt_q == FULL_CNT);
  assign ovrflw     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_low_freq_queue.sv
// Bench for low_freq_queue (DEPTH=8): a history-queue model predicts every
// readout into a scoreboard that a negedge monitor drains.
`default_nettype none

module tb_low_freq_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt_smpl = 1'b0;
  logic [15:0] lft_smpl = '0;
  logic [15:0] rght_smpl = '0;
  logic [15:0] lft_out, rght_out;
  logic        sequencing, full, ovrflw;

  low_freq_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wrt_smpl  (wrt_smpl),
    .lft_smpl  (lft_smpl),
    .rght_smpl (rght_smpl),
    .lft_out   (lft_out),
    .rght_out  (rght_out),
    .sequencing(sequencing),
    .full      (full),
    .ovrflw    (ovrflw)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] l; logic [15:0] r; } smpl_t;
  typedef struct { logic [15:0] l; logic [15:0] r; int c; } exp_t;

  smpl_t hist[$];
  exp_t  sb[$];
  int    cyc = 0;
  int    busy_until = -1;
  bit    exp_ovf = 1'b0;
  bit    exp_full_vis = 1'b0;
  bit    exp_ovf_vis = 1'b0;
  logic [15:0] last_l = '0, last_r = '0;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the last DEPTH accepted samples; a full queue after an
  // accepted write plays them back starting two cycles later, and writes
  // during the following DEPTH cycles are dropped and flag overflow.
  task automatic model_write(input logic [15:0] l, input logic [15:0] r);
    if (cyc > busy_until) begin
      hist.push_back('{l, r});
      if (hist.size() > DEPTH) void'(hist.pop_front());
      if (hist.size() == DEPTH) begin
        foreach (hist[i]) sb.push_back('{hist[i].l, hist[i].r, cyc + 2 + i});
        busy_until = cyc + DEPTH;
      end
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic step(input bit w, input logic [15:0] l, input logic [15:0] r);
    @(posedge clk);
    #1;
    wrt_smpl  = w;
    lft_smpl  = l;
    rght_smpl = r;
    if (w) model_write(l, r);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    wrt_smpl = 1'b0;
    hist.delete();
    sb.delete();
    busy_until = -1;
    exp_ovf    = 1'b0;
    #1;
    chk("rst_sequencing", int'(sequencing), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ovrflw", int'(ovrflw), 0);
    chk("rst_lft_out", int'(lft_out), 0);
    chk("rst_rght_out", int'(rght_out), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    exp_full_vis <= (hist.size() == DEPTH);
    exp_ovf_vis  <= exp_ovf;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last_l = '0;
      last_r = '0;
    end else begin
      chk("full", int'(full), int'(exp_full_vis));
      chk("ovrflw", int'(ovrflw), int'(exp_ovf_vis));
      if (sequencing) begin
        if (sb.size() == 0) begin
          chk("unexpected_sequencing", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("seq_cycle", cyc, e.c);
          chk("lft_out", int'(lft_out), int'(e.l));
          chk("rght_out", int'(rght_out), int'(e.r));
        end
      end else begin
        if (sb.size() != 0 && sb[0].c <= cyc) chk("missing_sequencing", cyc, sb[0].c);
        chk("lft_hold", int'(lft_out), int'(last_l));
        chk("rght_hold", int'(rght_out), int'(last_r));
      end
      last_l = lft_out;
      last_r = rght_out;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // 1..7 / -1..-7 with random gaps: no readout yet
    for (int i = 1; i <= 7; i++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, '0, '0);
      step(1'b1, 16'(i), 16'(-i));
    end
    step(1'b0, '0, '0);
    step(1'b1, 16'd8, 16'(-8));
    repeat (DEPTH + 3) step(1'b0, '0, '0);

    // Wrap: oldest entry overwritten, readout 2..9; 99 dropped mid-readout
    step(1'b1, 16'd9, 16'(-9));
    repeat (3) step(1'b0, '0, '0);
    step(1'b1, 16'd99, 16'(-99));
    repeat (DEPTH + 3) step(1'b0, '0, '0);

    // Reset on the fourth sequencing cycle, then a fresh fill
    step(1'b1, 16'd10, 16'(-10));
    repeat (4) step(1'b0, '0, '0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom));
      step(1'b0, '0, '0);
    end
    repeat (DEPTH + 3) step(1'b0, '0, '0);

    // Random traffic, including writes that collide with readouts
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0), 16'($urandom), 16'($urandom));
    end
    repeat (DEPTH + 4) step(1'b0, '0, '0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/low_freq_queue.md
LOW_FREQ_QUEUE -- requirements
Module: low_freq_queue

Interface
REQ-001: Parameter DEPTH, default 1021, sets the number of stereo samples held and read out per pass; DEPTH SHALL be at least 4.
REQ-002: Parameter AW, default 10, sets the pointer/counter width; 2^AW SHALL be at least DEPTH.
REQ-003: clk  input  1  rising-edge system clock.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: wrt_smpl  input  1  single-cycle strobe: new stereo sample present on lft_smpl/rght_smpl.
REQ-006: lft_smpl  input  16  signed left sample.
REQ-007: rght_smpl  input  16  signed right sample.
REQ-008: lft_out  output  16  signed left sample to the downstream FIR, registered.
REQ-009: rght_out  output  16  signed right sample to the downstream FIR, registered.
REQ-010: sequencing  output  1  high for exactly DEPTH consecutive cycles while lft_out/rght_out carry valid readout data, registered.
REQ-011: full  output  1  queue holds DEPTH samples.
REQ-012: ovrflw  output  1  sticky flag: a wrt_smpl arrived during a readout.

Function
REQ-013: Storage SHALL be two DEPTH x 16 arrays (left, right) with one synchronous write port and one synchronous read port; a read SHALL have 1-cycle latency.
REQ-014: new_ptr (write pointer) SHALL advance by 1 on every accepted write and SHALL wrap from DEPTH-1 to 0.
REQ-015: cnt SHALL count stored samples, increment on accepted writes, and saturate at DEPTH; full SHALL equal (cnt == DEPTH).
REQ-016: Once full, each accepted write SHALL overwrite the oldest entry; the oldest entry index SHALL then equal the post-write new_ptr.
REQ-017: The FSM SHALL have states IDLE and READ.
REQ-018: IDLE SHALL accept a write whenever wrt_smpl is high.
REQ-019: A write in IDLE that leaves cnt == DEPTH SHALL transition the FSM to READ on the next edge and load rd_ptr with the post-write new_ptr and rd_cnt with 0.
REQ-020: A write in IDLE that leaves cnt < DEPTH SHALL keep the FSM in IDLE with no readout.
REQ-021: In READ, the FSM SHALL present rd_ptr to the read port each cycle, then increment rd_ptr (wrapping DEPTH-1 to 0) and rd_cnt.
REQ-022: READ SHALL exit to IDLE after the cycle that issues rd_cnt == DEPTH-1, so exactly DEPTH addresses are issued, oldest to newest.
REQ-023: sequencing SHALL be the READ-state indication delayed one cycle so that it aligns with read data.
REQ-024: For a triggering write in cycle N, sequencing SHALL be high in cycles N+2 through N+1+DEPTH inclusive, carrying the oldest sample in N+2 and the just-written sample in N+1+DEPTH.
REQ-025: lft_out/rght_out SHALL update only while sequencing is high and SHALL hold their last value otherwise.
REQ-026: A wrt_smpl in READ SHALL be ignored: no memory write, no new_ptr or cnt change, and ovrflw set to 1.
REQ-027: ovrflw SHALL stay set until reset.
REQ-028: A wrt_smpl in the same cycle READ returns to IDLE SHALL be treated as an IDLE write only on the following cycle; the write in the exit cycle SHALL be ignored per REQ-026.
REQ-029: No arithmetic SHALL be applied to samples; data SHALL pass through bit-exact.

Reset
REQ-030: rst_n low SHALL asynchronously force state=IDLE; new_ptr, rd_ptr, rd_cnt and cnt to 0; and sequencing, full, ovrflw, lft_out and rght_out to 0.
REQ-031: Memory contents SHALL NOT be reset; a reset mid-READ SHALL abort the readout immediately, and a full fill of DEPTH writes SHALL be required before the next sequencing pulse.

Verification
REQ-032: Run with DEPTH=8 and write 1..7 to left and -1..-7 to right -> sequencing never asserts and full=0.
REQ-033: Continuing REQ-032, write 8/-8 in cycle N -> sequencing high in cycles N+2..N+9, lft_out=1,2,...,8 and rght_out=-1,...,-8, then full=1.
REQ-034: Then write 9 -> the readout is 2..9 in order, confirming pointer wrap and overwrite of the oldest entry.
REQ-035: Assert wrt_smpl with value 99 during a readout -> 99 never appears in any later readout, ovrflw=1, and the readout length stays 8.
REQ-036: Assert rst_n low at the 4th sequencing cycle -> all outputs 0 at once; after release, 7 writes give no sequencing and the 8th write starts a full readout.
REQ-037: Run the default DEPTH=1021 with writes every 1042 cycles of a ramp -> each readout is 1021 consecutive ramp values and ovrflw stays 0.
